// File: rtl/washer_pkg.sv
// rtl/washer_pkg.sv - shared state encoding and machine-phase decode for the wash sequencer
package washer_pkg;

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_WASH, WASH, WAIT_SPIN, SPIN, COMPLETE, FAULT
  } state_e;

  // Bit positions in the packed machine-phase status vector
  localparam int PH_MOTOR = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_SOAP  = 2;
  localparam int PH_WATER = 3;
  localparam int PH_W     = 4;

  localparam int WDOG_CYCLES_DEF = 1024;

  function automatic logic is_spin_ph(input logic [PH_W-1:0] ph);
    return ph[PH_MOTOR] & ph[PH_DRAIN];
  endfunction

  function automatic logic is_wash_ph(input logic [PH_W-1:0] ph);
    return ph[PH_MOTOR] & (ph[PH_SOAP] | ph[PH_WATER]) & ~ph[PH_DRAIN];
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that parks at zero and flags terminal count
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/wash_program_sequencer.sv
// rtl/wash_program_sequencer.sv - drives start/timeouts of the washing machine from latched durations
module wash_program_sequencer
  import washer_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_req,
  input  logic [CNT_W-1:0] wash_ticks,
  input  logic [CNT_W-1:0] spin_ticks,
  input  logic             door_lock,
  input  logic             motor_on,
  input  logic             drain_value_on,
  input  logic             soap_wash,
  input  logic             water_wash,
  input  logic             done,
  output logic             start,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       phase_cnt
);

  localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(WDOG_CYCLES - 1);

  // Timers count ticks-1 down to zero; a zero duration behaves like one
  function automatic logic [CNT_W-1:0] to_load(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

  function automatic logic is_active(input state_e s);
    return s inside {ARM, WAIT_WASH, WASH, WAIT_SPIN, SPIN};
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wash_lat_q, wash_lat_d, spin_lat_q, spin_lat_d;
  logic             start_q, start_d, cto_q, cto_d, sto_q, sto_d;
  logic             busy_q, busy_d, fault_q, fault_d, soap_prev_q;
  logic [2:0]       phase_q, phase_d;

  logic [PH_W-1:0]  ph;
  logic             wash_ph, spin_ph, accept, kind_chg;
  logic             dur_load, dur_en, dur_tc, wdog_load, wdog_en, wdog_tc;
  logic [CNT_W-1:0] dur_val;

  always_comb begin
    ph           = '0;
    ph[PH_MOTOR] = motor_on;
    ph[PH_DRAIN] = drain_value_on;
    ph[PH_SOAP]  = soap_wash;
    ph[PH_WATER] = water_wash;
  end

  assign spin_ph  = is_spin_ph(ph);
  assign wash_ph  = is_wash_ph(ph) & ~spin_ph;
  assign accept   = (state_q == IDLE) && start_req;
  assign kind_chg = (state_q == WASH) && wash_ph && soap_prev_q && !soap_wash && water_wash;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_req) state_d = ARM;
      ARM:       if (door_lock) state_d = WAIT_WASH;
      WAIT_WASH: if (wdog_tc) state_d = FAULT; else if (wash_ph) state_d = WASH;
      WASH:      if (!wash_ph) state_d = WAIT_SPIN;
      WAIT_SPIN: if (wdog_tc) state_d = FAULT; else if (spin_ph) state_d = SPIN;
      SPIN:      if (done) state_d = COMPLETE;
      COMPLETE:  if (!done) state_d = IDLE;
      FAULT:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign dur_load  = ((state_q == WAIT_WASH) && (state_d == WASH)) || kind_chg ||
                     ((state_q == WAIT_SPIN) && (state_d == SPIN));
  assign dur_val   = (state_d == SPIN) ? spin_lat_q : wash_lat_q;
  assign dur_en    = (state_q == WASH) || (state_q == SPIN);
  assign wdog_load = ((state_d == WAIT_WASH) || (state_d == WAIT_SPIN)) && (state_d != state_q);
  assign wdog_en   = (state_q == WAIT_WASH) || (state_q == WAIT_SPIN);

  // Outputs look at both sides of the edge so they fall on the edge that leaves a phase
  always_comb begin
    wash_lat_d = accept ? to_load(wash_ticks) : wash_lat_q;
    spin_lat_d = accept ? to_load(spin_ticks) : spin_lat_q;
    start_d    = is_active(state_q) && is_active(state_d);
    busy_d     = (state_q != IDLE) && (state_d != IDLE);
    cto_d      = (state_q == WASH) && (state_d == WASH) && !kind_chg && (cto_q || dur_tc);
    sto_d      = (state_q == SPIN) && (state_d == SPIN) && (sto_q || dur_tc);
    fault_d    = accept ? 1'b0 : (fault_q || (state_d == FAULT));
    phase_d    = phase_q;
    if (accept) begin
      phase_d = '0;
    end else if ((kind_chg || ((state_q == WASH) && (state_d == WAIT_SPIN))) && (phase_q != 3'd7)) begin
      phase_d = phase_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wash_lat_q  <= '0;
      spin_lat_q  <= '0;
      start_q     <= 1'b0;
      cto_q       <= 1'b0;
      sto_q       <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      phase_q     <= '0;
      soap_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wash_lat_q  <= wash_lat_d;
      spin_lat_q  <= spin_lat_d;
      start_q     <= start_d;
      cto_q       <= cto_d;
      sto_q       <= sto_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
      phase_q     <= phase_d;
      soap_prev_q <= soap_wash;
    end
  end

  phase_timer #(.CNT_W(CNT_W)) u_dur_timer (
    .clk(clk), .rst(reset), .load_i(dur_load), .en_i(dur_en),
    .load_val_i(dur_val), .tc_o(dur_tc)
  );

  phase_timer #(.CNT_W(CNT_W)) u_wdog_timer (
    .clk(clk), .rst(reset), .load_i(wdog_load), .en_i(wdog_en),
    .load_val_i(WDOG_LOAD), .tc_o(wdog_tc)
  );

  assign start         = start_q;
  assign cycle_timeout = cto_q;
  assign spin_timeout  = sto_q;
  assign busy          = busy_q;
  assign fault         = fault_q;
  assign phase_cnt     = phase_q;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// tb/tb_wash_program_sequencer.sv - self-checking bench for wash_program_sequencer
module tb_wash_program_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_req = 1'b0;
  logic [15:0] wash_ticks = '0, spin_ticks = '0;
  logic        door_lock = 1'b0, motor_on = 1'b0, drain_value_on = 1'b0;
  logic        soap_wash = 1'b0, water_wash = 1'b0, done = 1'b0;
  logic        start, cycle_timeout, spin_timeout, busy, fault;
  logic [2:0]  phase_cnt;

  int total = 0, passed = 0, cyc = 0;
  int exp_cto[$], exp_sto[$];
  logic cto_prev = 1'b0, sto_prev = 1'b0;
  int e_cto, e_sto, wd_entry;

  typedef struct {
    logic [15:0] wash;
    logic [15:0] spin;
    int          cto_lat;
    int          sto_lat;
  } vec_t;
  vec_t vecs[4];

  wash_program_sequencer #(.CNT_W(16), .WDOG_CYCLES(16)) dut (
    .clk(clk), .reset(rst), .start_req(start_req),
    .wash_ticks(wash_ticks), .spin_ticks(spin_ticks),
    .door_lock(door_lock), .motor_on(motor_on), .drain_value_on(drain_value_on),
    .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
    .start(start), .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
    .busy(busy), .fault(fault), .phase_cnt(phase_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard: timeout rises must land on the cycle pushed when the phase was entered
  always @(negedge clk) begin
    if (cycle_timeout && !cto_prev) begin
      if (exp_cto.size() == 0) begin
        total++;
        $display("FAIL cto_rise: unexpected rise at cycle %0d, required none", cyc);
      end else begin
        e_cto = exp_cto.pop_front();
        check("cto_rise_cycle", cyc, e_cto);
      end
    end
    if (spin_timeout && !sto_prev) begin
      if (exp_sto.size() == 0) begin
        total++;
        $display("FAIL sto_rise: unexpected rise at cycle %0d, required none", cyc);
      end else begin
        e_sto = exp_sto.pop_front();
        check("sto_rise_cycle", cyc, e_sto);
      end
    end
    cto_prev = cycle_timeout;
    sto_prev = spin_timeout;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_prog(input logic [15:0] w, input logic [15:0] s);
    wash_ticks = w; spin_ticks = s; start_req = 1'b1;
    step(1);
    start_req = 1'b0; wash_ticks = 16'hBEEF; spin_ticks = 16'hBEEF;
  endtask

  task automatic enter_wash(input int lat);
    door_lock = 1'b1;
    step(1);
    check("start_high", start, 1);
    check("busy_high", busy, 1);
    motor_on = 1'b1; soap_wash = 1'b1;
    step(1);
    exp_cto.push_back(cyc + lat);
  endtask

  task automatic leave_wash(input int exp_phase);
    motor_on = 1'b0; soap_wash = 1'b0; water_wash = 1'b0;
    step(1);
    check("cto_fall_on_exit", cycle_timeout, 0);
    check("phase_cnt_after_wash", phase_cnt, exp_phase);
  endtask

  task automatic run_spin(input int lat);
    motor_on = 1'b1; drain_value_on = 1'b1;
    step(1);
    exp_sto.push_back(cyc + lat);
  endtask

  task automatic finish_prog();
    done = 1'b1; motor_on = 1'b0; drain_value_on = 1'b0;
    step(1);
    check("sto_fall_on_exit", spin_timeout, 0);
    check("start_low_complete", start, 0);
    done = 1'b0; door_lock = 1'b0;
    step(1);
    check("busy_low_idle", busy, 0);
  endtask

  initial begin
    vecs[0] = '{16'd4, 16'd3, 4, 3};
    vecs[1] = '{16'd0, 16'd0, 1, 1};
    vecs[2] = '{16'd1, 16'd2, 1, 2};
    vecs[3] = '{16'd7, 16'd5, 7, 5};

    step(2);
    check("rst_start", start, 0);
    check("rst_cto", cycle_timeout, 0);
    check("rst_sto", spin_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_phase", phase_cnt, 0);
    rst = 1'b0;
    step(1);

    for (int i = 0; i < 4; i++) begin
      start_prog(vecs[i].wash, vecs[i].spin);
      check("start_lat_n", start, 0);
      check("busy_lat_n", busy, 0);
      enter_wash(vecs[i].cto_lat);
      step(vecs[i].cto_lat + 1);
      check("cto_hold", cycle_timeout, 1);
      leave_wash(1);
      run_spin(vecs[i].sto_lat);
      step(vecs[i].sto_lat + 1);
      check("sto_hold", spin_timeout, 1);
      finish_prog();
      check("final_phase", phase_cnt, 1);
      check("final_fault", fault, 0);
    end

    // Soap to water inside one WASH restarts the timer
    start_prog(16'd3, 16'd2);
    enter_wash(3);
    step(4);
    check("kind_cto_first", cycle_timeout, 1);
    soap_wash = 1'b0; water_wash = 1'b1;
    step(1);
    check("kind_cto_drop", cycle_timeout, 0);
    check("kind_phase_inc", phase_cnt, 1);
    exp_cto.push_back(cyc + 3);
    step(4);
    check("kind_cto_second", cycle_timeout, 1);
    leave_wash(2);
    run_spin(2);
    step(3);
    finish_prog();
    check("kind_final_phase", phase_cnt, 2);

    // start_req during SPIN must not disturb the latched spin duration
    start_prog(16'd2, 16'd5);
    enter_wash(2);
    step(3);
    leave_wash(1);
    run_spin(5);
    start_req = 1'b1; wash_ticks = 16'd1; spin_ticks = 16'd1;
    step(1);
    start_req = 1'b0;
    check("spin_req_busy", busy, 1);
    check("spin_req_phase", phase_cnt, 1);
    step(5);
    check("spin_req_sto", spin_timeout, 1);
    finish_prog();

    // Stuck fill: watchdog fires after 16 cycles in WAIT_WASH
    start_prog(16'd2, 16'd2);
    door_lock = 1'b1;
    step(1);
    wd_entry = cyc;
    step(15);
    check("wdog_fault_early", fault, 0);
    check("wdog_busy_early", busy, 1);
    step(1);
    check("wdog_cycle", cyc - wd_entry, 16);
    check("wdog_fault", fault, 1);
    check("wdog_start_low", start, 0);
    step(1);
    check("wdog_busy_low", busy, 0);
    check("wdog_fault_held", fault, 1);
    step(1);
    check("wdog_fault_sticky", fault, 1);
    door_lock = 1'b0;
    start_prog(16'd2, 16'd2);
    check("fault_cleared", fault, 0);

    // Asynchronous reset in the middle of WASH
    enter_wash(2);
    step(3);
    check("pre_rst_cto", cycle_timeout, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_start", start, 0);
    check("arst_cto", cycle_timeout, 0);
    check("arst_busy", busy, 0);
    check("arst_fault", fault, 0);
    check("arst_phase", phase_cnt, 0);
    step(1);
    rst = 1'b0;
    door_lock = 1'b0; motor_on = 1'b0; soap_wash = 1'b0;
    step(1);
    check("post_rst_busy", busy, 0);
    start_prog(16'd1, 16'd1);
    step(1);
    check("post_rst_restart", start, 1);

    check("cto_queue_empty", exp_cto.size(), 0);
    check("sto_queue_empty", exp_sto.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
